// File: rtl/reset_sequencer.sv
// Staged reset controller: holds all stages asserted for a minimum time and waits for a stable
// lock. It then releases the stages in index order with a fixed gap between them.
module reset_sequencer #(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned MIN_ASSERT = 32,
  parameter int unsigned LOCK_CYC   = 16,
  parameter int unsigned GAP_CYC    = 8
) (
  input  logic                  clk_dst,
  input  logic                  rst_in_n,
  input  logic                  locked,
  input  logic                  soft_rst_req,
  output logic [NUM_STAGES-1:0] rst_stage,
  output logic                  seq_done,
  output logic [1:0]            state_o
);

  localparam int unsigned CntMax0 = (MIN_ASSERT > LOCK_CYC) ? MIN_ASSERT : LOCK_CYC;
  localparam int unsigned CntMax  = (CntMax0 > GAP_CYC) ? CntMax0 : GAP_CYC;
  localparam int unsigned CW      = $clog2(CntMax + 1);
  localparam int unsigned IW      = $clog2(NUM_STAGES) + 1;

  typedef enum logic [1:0] {
    StAssert   = 2'd0,
    StWaitLock = 2'd1,
    StRelease  = 2'd2,
    StRun      = 2'd3
  } state_e;

  state_e                r_state;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [NUM_STAGES-1:0] r_rst_stage;
  logic                  r_done;

  logic [CW-1:0]         w_cnt_inc;
  logic [NUM_STAGES-1:0] w_idx_mask;

  // Counter saturates instead of wrapping.
  assign w_cnt_inc = (r_cnt == CW'(CntMax)) ? r_cnt : r_cnt + CW'(1);

  always_comb begin
    w_idx_mask = '0;
    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      w_idx_mask[i] = (r_idx == IW'(i));
    end
  end

  always_ff @(posedge clk_dst) begin
    if (!rst_in_n) begin
      r_state     <= StAssert;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_rst_stage <= '1;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        StAssert: begin
          r_rst_stage <= '1;
          r_done      <= 1'b0;
          if (soft_rst_req) begin
            r_cnt <= '0;
          end else if (r_cnt == CW'(MIN_ASSERT - 1)) begin
            r_state <= StWaitLock;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        StWaitLock: begin
          if (soft_rst_req) begin
            r_state     <= StAssert;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_rst_stage <= '1;
            r_done      <= 1'b0;
          end else if (!locked) begin
            r_cnt <= '0;
          end else if (r_cnt == CW'(LOCK_CYC - 1)) begin
            r_rst_stage <= r_rst_stage & ~NUM_STAGES'(1);
            r_cnt       <= '0;
            if (NUM_STAGES == 1) begin
              r_state <= StRun;
              r_done  <= 1'b1;
            end else begin
              r_state <= StRelease;
              r_idx   <= IW'(1);
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        StRelease: begin
          if (soft_rst_req || !locked) begin
            r_state     <= StAssert;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_rst_stage <= '1;
            r_done      <= 1'b0;
          end else if (r_cnt == CW'(GAP_CYC - 1)) begin
            r_rst_stage <= r_rst_stage & ~w_idx_mask;
            r_cnt       <= '0;
            if (r_idx == IW'(NUM_STAGES - 1)) begin
              r_state <= StRun;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        StRun: begin
          if (soft_rst_req || !locked) begin
            r_state     <= StAssert;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_rst_stage <= '1;
            r_done      <= 1'b0;
          end
        end
        default: begin
          r_state     <= StAssert;
          r_cnt       <= '0;
          r_idx       <= '0;
          r_rst_stage <= '1;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  assign rst_stage = r_rst_stage;
  assign seq_done  = r_done;
  assign state_o   = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default instance plus a minimal 1-stage instance, checked against a
// table of expected outputs at given edges (n = edges since rst_in_n went high).
module tb_reset_sequencer;

  logic       clk_dst = 1'b0;
  logic       rst_in_n;
  logic       locked;
  logic       soft_rst_req;
  logic [2:0] rs0;
  logic       done0;
  logic [1:0] st0;
  logic [0:0] rs1;
  logic       done1;
  logic [1:0] st1;

  always #5 clk_dst = ~clk_dst;

  reset_sequencer dut0 (
    .clk_dst      (clk_dst),
    .rst_in_n     (rst_in_n),
    .locked       (locked),
    .soft_rst_req (soft_rst_req),
    .rst_stage    (rs0),
    .seq_done     (done0),
    .state_o      (st0)
  );

  reset_sequencer #(
    .NUM_STAGES (1),
    .MIN_ASSERT (1),
    .LOCK_CYC   (1),
    .GAP_CYC    (1)
  ) dut1 (
    .clk_dst      (clk_dst),
    .rst_in_n     (rst_in_n),
    .locked       (locked),
    .soft_rst_req (soft_rst_req),
    .rst_stage    (rs1),
    .seq_done     (done1),
    .state_o      (st1)
  );

  typedef struct {
    int         scen;
    int         n;
    int         dut;
    logic [2:0] stage;
    logic       done;
    logic [1:0] st;
  } chk_t;

  chk_t tbl[$];
  chk_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(int s, int n, int d, logic [2:0] stg, logic dn, logic [1:0] so);
    chk_t c;
    c.scen = s; c.n = n; c.dut = d; c.stage = stg; c.done = dn; c.st = so;
    tbl.push_back(c);
  endfunction

  // Input values as sampled at edge n of scenario s.
  function automatic logic f_locked(int s, int n);
    case (s)
      2:       return !(n <= 40 || n == 51);
      3:       return n != 101;
      6:       return n != 64;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic f_soft(int s, int n);
    return (s == 4) && (n == 59 || n == 70);
  endfunction

  function automatic logic f_rstn(int s, int n);
    return !((s == 5) && (n == 60));
  endfunction

  task automatic push_rows(input int s, input int n);
    foreach (tbl[i]) if (tbl[i].scen == s && tbl[i].n == n) exp_q.push_back(tbl[i]);
  endtask

  task automatic pop_and_check();
    chk_t       e;
    logic [2:0] a_stage;
    logic       a_done;
    logic [1:0] a_st;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.dut == 0) begin
        a_stage = rs0; a_done = done0; a_st = st0;
      end else begin
        a_stage = {2'b00, rs1}; a_done = done1; a_st = st1;
      end
      checks++;
      if (a_stage !== e.stage || a_done !== e.done || a_st !== e.st) begin
        errors++;
        $display("FAIL s%0d n%0d dut%0d: got stage=%b done=%b state=%0d, want stage=%b done=%b state=%0d",
                 e.scen, e.n, e.dut, a_stage, a_done, a_st, e.stage, e.done, e.st);
      end
    end
  endtask

  task automatic run(input int s, input int last);
    rst_in_n     = 1'b0;
    soft_rst_req = 1'b0;
    locked       = f_locked(s, 0);
    repeat (4) @(posedge clk_dst);
    push_rows(s, 0);
    @(posedge clk_dst);
    #1;
    pop_and_check();
    for (int n = 1; n <= last; n++) begin
      rst_in_n     = f_rstn(s, n);
      locked       = f_locked(s, n);
      soft_rst_req = f_soft(s, n);
      push_rows(s, n);
      @(posedge clk_dst);
      #1;
      pop_and_check();
    end
  endtask

  initial begin
    rst_in_n     = 1'b0;
    locked       = 1'b0;
    soft_rst_req = 1'b0;

    // 1: nominal sequence, locked high throughout.
    add(1, 0, 0, 3'b111, 0, 0);  add(1, 1, 0, 3'b111, 0, 0);  add(1, 31, 0, 3'b111, 0, 0);
    add(1, 32, 0, 3'b111, 0, 1); add(1, 47, 0, 3'b111, 0, 1); add(1, 48, 0, 3'b110, 0, 2);
    add(1, 55, 0, 3'b110, 0, 2); add(1, 56, 0, 3'b100, 0, 2); add(1, 63, 0, 3'b100, 0, 2);
    add(1, 64, 0, 3'b000, 1, 3); add(1, 70, 0, 3'b000, 1, 3);
    add(1, 0, 1, 3'b001, 0, 0);  add(1, 1, 1, 3'b001, 0, 1);  add(1, 2, 1, 3'b000, 1, 3);
    add(1, 5, 1, 3'b000, 1, 3);
    // 2: lock arrives late, then glitches low once and the count restarts.
    add(2, 48, 0, 3'b111, 0, 1); add(2, 56, 0, 3'b111, 0, 1); add(2, 66, 0, 3'b111, 0, 1);
    add(2, 67, 0, 3'b110, 0, 2); add(2, 75, 0, 3'b100, 0, 2); add(2, 83, 0, 3'b000, 1, 3);
    // 3: one-cycle lock loss while running.
    add(3, 100, 0, 3'b000, 1, 3); add(3, 101, 0, 3'b111, 0, 0); add(3, 132, 0, 3'b111, 0, 0);
    add(3, 133, 0, 3'b111, 0, 1); add(3, 148, 0, 3'b111, 0, 1); add(3, 149, 0, 3'b110, 0, 2);
    add(3, 165, 0, 3'b000, 1, 3);
    // 4: soft request in RELEASE, then again in ASSERT extending the hold.
    add(4, 58, 0, 3'b100, 0, 2); add(4, 59, 0, 3'b111, 0, 0); add(4, 70, 0, 3'b111, 0, 0);
    add(4, 101, 0, 3'b111, 0, 0); add(4, 102, 0, 3'b111, 0, 1); add(4, 118, 0, 3'b110, 0, 2);
    add(4, 134, 0, 3'b000, 1, 3);
    // 5: one-cycle rst_in_n mid-RELEASE; timing restarts from edge 61.
    add(5, 59, 0, 3'b100, 0, 2); add(5, 60, 0, 3'b111, 0, 0); add(5, 91, 0, 3'b111, 0, 0);
    add(5, 92, 0, 3'b111, 0, 1); add(5, 107, 0, 3'b111, 0, 1); add(5, 108, 0, 3'b110, 0, 2);
    add(5, 116, 0, 3'b100, 0, 2); add(5, 124, 0, 3'b000, 1, 3);
    // 6: lock loss on the edge the last stage would release; seq_done never pulses.
    add(6, 63, 0, 3'b100, 0, 2); add(6, 64, 0, 3'b111, 0, 0); add(6, 65, 0, 3'b111, 0, 0);

    run(1, 70);
    run(2, 83);
    run(3, 165);
    run(4, 134);
    run(5, 124);
    run(6, 65);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
